// File: rtl/s_cycle_arbiter.sv
// Memory-cycle controller for the S address register: runs the 12-timepulse cycle,
// arbitrates S loads among CTR/SEQ/MON and sequences the S and parity strobes.
module s_cycle_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int ALARM_THRESH = 2,
    parameter int STARVE_MAX   = 4
) (
    input  logic              SIM_CLK,
    input  logic              SIM_RST,
    input  logic              EN,
    input  logic              CTR_REQ,
    input  logic [ADDR_W-1:0] CTR_ADDR,
    input  logic              SEQ_REQ,
    input  logic              SEQ_WR,
    input  logic [ADDR_W-1:0] SEQ_ADDR,
    input  logic              MON_REQ,
    input  logic              MON_WR,
    input  logic [ADDR_W-1:0] MON_ADDR,
    input  logic              PAR_OK,
    input  logic              ALARM_CLR,
    output logic [2:0]        GNT,
    output logic [3:0]        TP,
    output logic              CSG,
    output logic              WSG_n,
    output logic [ADDR_W-1:0] WL_OUT,
    output logic              TPARG_n,
    output logic              PCHK,
    output logic              PALE,
    output logic [7:0]        ERR_CNT,
    output logic              BUSY
);

    localparam logic [2:0] GNT_SEQ    = 3'b001;
    localparam logic [2:0] GNT_CTR    = 3'b010;
    localparam logic [2:0] GNT_MON    = 3'b100;
    localparam logic [3:0] TP_LAST    = 4'd12;
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
    localparam logic [2:0] FAIL_LIM   = 3'(ALARM_THRESH);
    localparam logic [2:0] FAIL_SAT   = 3'd7;
    localparam logic [7:0] ERR_SAT    = 8'd255;

    // Timepulse state
    logic [3:0]        tp_q, tp_d;
    logic              en_q, en_d;

    // Grant state for the current cycle
    logic [2:0]        gnt_q, gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [7:0]        starve_q, starve_d;

    // Parity bookkeeping
    logic [2:0]        fail_q, fail_d;
    logic              pale_q, pale_d;
    logic [7:0]        err_q, err_d;

    // Registered strobes
    logic              csg_q, csg_d;
    logic              wsg_n_q, wsg_n_d;
    logic [ADDR_W-1:0] wl_q, wl_d;
    logic              pchk_q, pchk_d;
    logic              tparg_n_q, tparg_n_d;

    logic              arb_now;
    logic [2:0]        win;
    logic              granted;
    logic              hit_tp1;
    logic              hit_tp2;
    logic              hit_tp7;
    logic              hit_tp10;
    logic [2:0]        fail_base;
    logic              pale_base;

    always_comb begin
        tp_d = tp_q;
        if (EN) begin
            tp_d = (tp_q == TP_LAST) ? 4'd1 : tp_q + 4'd1;
        end
        // en_q remembers that the last clock entered the timepulse now in tp_q
        en_d = EN;
    end

    assign arb_now = EN && (tp_q == TP_LAST);

    always_comb begin
        win = 3'b000;
        if (MON_REQ && (starve_q == STARVE_LIM)) begin
            win = GNT_MON;
        end else if (CTR_REQ) begin
            win = GNT_CTR;
        end else if (SEQ_REQ) begin
            win = GNT_SEQ;
        end else if (MON_REQ) begin
            win = GNT_MON;
        end
    end

    always_comb begin
        gnt_d    = gnt_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        starve_d = starve_q;
        if (arb_now) begin
            gnt_d = win;
            case (win)
                GNT_CTR: begin
                    addr_d = CTR_ADDR;
                    wr_d   = 1'b1;
                end
                GNT_SEQ: begin
                    addr_d = SEQ_ADDR;
                    wr_d   = SEQ_WR;
                end
                GNT_MON: begin
                    addr_d = MON_ADDR;
                    wr_d   = MON_WR;
                end
                default: begin
                    addr_d = '0;
                    wr_d   = 1'b0;
                end
            endcase
            if (!MON_REQ || (win == GNT_MON)) begin
                starve_d = '0;
            end else if (starve_q != STARVE_LIM) begin
                starve_d = starve_q + 8'd1;
            end
        end
    end

    assign granted  = |gnt_q;
    assign hit_tp1  = granted && en_q && (tp_q == 4'd1);
    assign hit_tp2  = granted && en_q && (tp_q == 4'd2);
    assign hit_tp7  = granted && en_q && (tp_q == 4'd7);
    assign hit_tp10 = granted && en_q && (tp_q == 4'd10);

    always_comb begin
        csg_d     = hit_tp1;
        wsg_n_d   = !hit_tp2;
        wl_d      = hit_tp2 ? addr_q : '0;
        // CTR cycles are read-modify-write, so they get both the check and the generate
        pchk_d    = hit_tp7 && (!wr_q || (gnt_q == GNT_CTR));
        tparg_n_d = !(hit_tp10 && wr_q);
    end

    always_comb begin
        fail_base = ALARM_CLR ? 3'd0 : fail_q;
        pale_base = ALARM_CLR ? 1'b0 : pale_q;
        fail_d    = fail_base;
        pale_d    = pale_base;
        err_d     = err_q;
        if (pchk_d) begin
            if (!PAR_OK) begin
                if (err_q != ERR_SAT) begin
                    err_d = err_q + 8'd1;
                end
                fail_d = (fail_base == FAIL_SAT) ? FAIL_SAT : fail_base + 3'd1;
                if (fail_d >= FAIL_LIM) begin
                    pale_d = 1'b1;
                end
            end else begin
                fail_d = 3'd0;
            end
        end
    end

    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            tp_q      <= TP_LAST;
            en_q      <= 1'b0;
            gnt_q     <= 3'b000;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            starve_q  <= '0;
            fail_q    <= 3'd0;
            pale_q    <= 1'b0;
            err_q     <= 8'd0;
            csg_q     <= 1'b0;
            wsg_n_q   <= 1'b1;
            wl_q      <= '0;
            pchk_q    <= 1'b0;
            tparg_n_q <= 1'b1;
        end else begin
            tp_q      <= tp_d;
            en_q      <= en_d;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            starve_q  <= starve_d;
            fail_q    <= fail_d;
            pale_q    <= pale_d;
            err_q     <= err_d;
            csg_q     <= csg_d;
            wsg_n_q   <= wsg_n_d;
            wl_q      <= wl_d;
            pchk_q    <= pchk_d;
            tparg_n_q <= tparg_n_d;
        end
    end

    assign GNT     = gnt_q;
    assign BUSY    = granted;
    assign TP      = tp_q;
    assign CSG     = csg_q;
    assign WSG_n   = wsg_n_q;
    assign WL_OUT  = wl_q;
    assign TPARG_n = tparg_n_q;
    assign PCHK    = pchk_q;
    assign PALE    = pale_q;
    assign ERR_CNT = err_q;

endmodule

// File: tb/tb_s_cycle_arbiter.sv
// Directed bench for s_cycle_arbiter: a cycle-level reference model checked every clock,
// plus hand-computed expectations at the interesting points of each scenario.
module tb_s_cycle_arbiter;

    localparam int ADDR_W       = 12;
    localparam int ALARM_THRESH = 2;
    localparam int STARVE_MAX   = 4;

    logic              SIM_CLK;
    logic              SIM_RST;
    logic              EN;
    logic              CTR_REQ;
    logic [ADDR_W-1:0] CTR_ADDR;
    logic              SEQ_REQ;
    logic              SEQ_WR;
    logic [ADDR_W-1:0] SEQ_ADDR;
    logic              MON_REQ;
    logic              MON_WR;
    logic [ADDR_W-1:0] MON_ADDR;
    logic              PAR_OK;
    logic              ALARM_CLR;
    logic [2:0]        GNT;
    logic [3:0]        TP;
    logic              CSG;
    logic              WSG_n;
    logic [ADDR_W-1:0] WL_OUT;
    logic              TPARG_n;
    logic              PCHK;
    logic              PALE;
    logic [7:0]        ERR_CNT;
    logic              BUSY;

    int checks = 0;
    int errors = 0;

    s_cycle_arbiter #(
        .ADDR_W       (ADDR_W),
        .ALARM_THRESH (ALARM_THRESH),
        .STARVE_MAX   (STARVE_MAX)
    ) dut (
        .SIM_CLK   (SIM_CLK),
        .SIM_RST   (SIM_RST),
        .EN        (EN),
        .CTR_REQ   (CTR_REQ),
        .CTR_ADDR  (CTR_ADDR),
        .SEQ_REQ   (SEQ_REQ),
        .SEQ_WR    (SEQ_WR),
        .SEQ_ADDR  (SEQ_ADDR),
        .MON_REQ   (MON_REQ),
        .MON_WR    (MON_WR),
        .MON_ADDR  (MON_ADDR),
        .PAR_OK    (PAR_OK),
        .ALARM_CLR (ALARM_CLR),
        .GNT       (GNT),
        .TP        (TP),
        .CSG       (CSG),
        .WSG_n     (WSG_n),
        .WL_OUT    (WL_OUT),
        .TPARG_n   (TPARG_n),
        .PCHK      (PCHK),
        .PALE      (PALE),
        .ERR_CNT   (ERR_CNT),
        .BUSY      (BUSY)
    );

    initial begin
        SIM_CLK = 1'b0;
        forever #5 SIM_CLK = ~SIM_CLK;
    end

    // Reference model: one cycle = 12 timepulses; 'entered' is the timepulse reached on
    // the previous clock (0 if the clock did not advance), and strobes follow it by one clock.
    int          m_tp      = 12;
    int          m_entered = 0;
    logic [2:0]  m_gnt     = 3'b000;
    logic [11:0] m_addr    = 12'h000;
    logic        m_wr      = 1'b0;
    int          m_starve  = 0;
    int          m_fail    = 0;
    logic        m_pale    = 1'b0;
    int          m_err     = 0;
    logic        e_csg     = 1'b0;
    logic        e_wsg_n   = 1'b1;
    logic [11:0] e_wl      = 12'h000;
    logic        e_pchk    = 1'b0;
    logic        e_tparg_n = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_arbitrate();
        logic [2:0] w;
        w = 3'b000;
        if (MON_REQ && m_starve == STARVE_MAX) w = 3'b100;
        else if (CTR_REQ)                      w = 3'b010;
        else if (SEQ_REQ)                      w = 3'b001;
        else if (MON_REQ)                      w = 3'b100;
        m_gnt = w;
        case (w)
            3'b010:  begin m_addr = CTR_ADDR; m_wr = 1'b1;   end
            3'b001:  begin m_addr = SEQ_ADDR; m_wr = SEQ_WR; end
            3'b100:  begin m_addr = MON_ADDR; m_wr = MON_WR; end
            default: begin m_addr = 12'h000;  m_wr = 1'b0;   end
        endcase
        if (!MON_REQ || w == 3'b100) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
        if (w != 3'b000)
            $display("txn t=%0t gnt=%b addr=%h wr=%0d", $time, w, m_addr, m_wr);
    endtask

    task automatic model_step();
        logic busy;
        if (!SIM_RST) begin
            m_tp = 12; m_entered = 0; m_gnt = 3'b000; m_addr = 12'h000; m_wr = 1'b0;
            m_starve = 0; m_fail = 0; m_pale = 1'b0; m_err = 0;
            e_csg = 1'b0; e_wsg_n = 1'b1; e_wl = 12'h000; e_pchk = 1'b0; e_tparg_n = 1'b1;
            return;
        end
        busy      = (m_gnt != 3'b000);
        e_csg     = busy && m_entered == 1;
        e_wsg_n   = !(busy && m_entered == 2);
        e_wl      = e_wsg_n ? 12'h000 : m_addr;
        e_pchk    = busy && m_entered == 7 && (!m_wr || m_gnt == 3'b010);
        e_tparg_n = !(busy && m_entered == 10 && m_wr);
        if (ALARM_CLR) begin
            m_pale = 1'b0;
            m_fail = 0;
        end
        if (e_pchk) begin
            if (!PAR_OK) begin
                if (m_err < 255) m_err = m_err + 1;
                if (m_fail < 7) m_fail = m_fail + 1;
                if (m_fail >= ALARM_THRESH) m_pale = 1'b1;
            end else begin
                m_fail = 0;
            end
        end
        if (EN) begin
            if (m_tp == 12) model_arbitrate();
            m_tp      = (m_tp % 12) + 1;
            m_entered = m_tp;
        end else begin
            m_entered = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge SIM_CLK);
            model_step();
            #1;
            chk("cycle", 64'({GNT, TP, CSG, WSG_n, WL_OUT, TPARG_n, PCHK, PALE, ERR_CNT, BUSY}),
                64'({m_gnt, 4'(m_tp), e_csg, e_wsg_n, e_wl, e_tparg_n, e_pchk, m_pale,
                     8'(m_err), (m_gnt != 3'b000)}));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge SIM_CLK);
    endtask

    task automatic wait_tp(input int n);
        int k;
        k = 0;
        while (m_tp != n && k < 40) begin
            @(negedge SIM_CLK);
            k++;
        end
        if (m_tp != n) begin
            checks++;
            errors++;
            $display("FAIL wait_tp: model tp %0d, wanted %0d", m_tp, n);
        end
    endtask

    logic [2:0] starve_exp [6];

    initial begin
        starve_exp[0] = 3'b001; starve_exp[1] = 3'b001; starve_exp[2] = 3'b001;
        starve_exp[3] = 3'b001; starve_exp[4] = 3'b100; starve_exp[5] = 3'b001;

        SIM_RST = 1'b0; EN = 1'b0;
        CTR_REQ = 1'b0; CTR_ADDR = '0;
        SEQ_REQ = 1'b0; SEQ_WR = 1'b0; SEQ_ADDR = '0;
        MON_REQ = 1'b0; MON_WR = 1'b0; MON_ADDR = '0;
        PAR_OK = 1'b1; ALARM_CLR = 1'b0;
        tick(3);
        chk("rst_tp", 64'(TP), 64'd12);
        chk("rst_gnt", 64'(GNT), 64'd0);
        chk("rst_strobes", 64'({CSG, WSG_n, TPARG_n, PCHK}), 64'b0110);
        chk("rst_alarm", 64'({PALE, ERR_CNT, BUSY, WL_OUT}), 64'd0);

        // Idle cycle: timepulses run with no grant
        SIM_RST = 1'b1; EN = 1'b1;
        tick(1);
        chk("idle_tp1", 64'(TP), 64'd1);
        chk("idle_gnt", 64'({GNT, BUSY}), 64'd0);
        wait_tp(12);
        chk("idle_tp12", 64'(TP), 64'd12);

        // All three request: CTR wins and runs a full read-modify-write
        CTR_REQ = 1'b1; CTR_ADDR = 12'hABC;
        SEQ_REQ = 1'b1; SEQ_ADDR = 12'h123; SEQ_WR = 1'b0;
        MON_REQ = 1'b1; MON_ADDR = 12'h456; MON_WR = 1'b1;
        tick(1);
        chk("ctr_gnt", 64'({GNT, BUSY}), 64'b0101);
        CTR_REQ = 1'b0; MON_REQ = 1'b0;
        tick(1);
        chk("ctr_csg", 64'(CSG), 64'd1);
        tick(1);
        chk("ctr_wsg", 64'({WSG_n, WL_OUT}), 64'h0ABC);
        tick(5);
        chk("ctr_pchk", 64'(PCHK), 64'd1);
        tick(3);
        chk("ctr_tparg", 64'(TPARG_n), 64'd0);

        // SEQ wins while MON idle, then MON starves for four cycles and is forced in
        wait_tp(12);
        tick(1);
        chk("seq_gnt", 64'(GNT), 64'b001);
        MON_REQ = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_tp(12);
            tick(1);
            chk("starve_gnt", 64'(GNT), 64'(starve_exp[i]));
        end

        // Parity: two consecutive failing reads raise the alarm
        MON_REQ = 1'b0; PAR_OK = 1'b0;
        wait_tp(12);
        chk("par_a", 64'({PALE, ERR_CNT}), 64'h001);
        tick(1);
        wait_tp(12);
        chk("par_b", 64'({PALE, ERR_CNT}), 64'h102);
        ALARM_CLR = 1'b1;
        tick(1);
        ALARM_CLR = 1'b0;
        chk("par_clr", 64'({PALE, ERR_CNT}), 64'h002);
        wait_tp(12);
        chk("par_c", 64'({PALE, ERR_CNT}), 64'h003);
        PAR_OK = 1'b1;
        tick(1);
        wait_tp(12);
        chk("par_d_pass", 64'({PALE, ERR_CNT}), 64'h003);
        PAR_OK = 1'b0;
        tick(1);
        wait_tp(12);
        chk("par_e", 64'({PALE, ERR_CNT}), 64'h004);
        tick(1);
        wait_tp(12);
        chk("par_f", 64'({PALE, ERR_CNT}), 64'h105);

        // Clear lands on the same clock as a failing check
        tick(1);
        wait_tp(7);
        ALARM_CLR = 1'b1;
        tick(1);
        ALARM_CLR = 1'b0;
        chk("clr_same_clk", 64'({PCHK, PALE, ERR_CNT}), 64'h206);
        wait_tp(12);
        tick(1);
        wait_tp(12);
        chk("clr_count_one", 64'({PALE, ERR_CNT}), 64'h107);

        // Reset in the middle of a MON write cycle
        SEQ_REQ = 1'b0; PAR_OK = 1'b1;
        MON_REQ = 1'b1; MON_WR = 1'b1; MON_ADDR = 12'h456;
        tick(1);
        chk("mon_gnt", 64'(GNT), 64'b100);
        wait_tp(5);
        SIM_RST = 1'b0;
        tick(1);
        chk("midrst_state", 64'({TP, GNT, BUSY, TPARG_n}), 64'({4'd12, 3'b000, 1'b0, 1'b1}));
        chk("midrst_alarm", 64'({PALE, ERR_CNT}), 64'h000);
        SIM_RST = 1'b1;
        tick(1);
        chk("regrant", 64'({TP, GNT}), 64'({4'd1, 3'b100}));
        MON_REQ = 1'b0;
        tick(3);
        chk("en_run_tp", 64'(TP), 64'd4);
        EN = 1'b0;
        tick(3);
        chk("en_hold", 64'({TP, BUSY}), 64'({4'd4, 1'b1}));
        EN = 1'b1;
        wait_tp(12);
        tick(14);
        chk("final_idle", 64'({GNT, BUSY}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
